// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream program loader for the instruction memory
module imem_boot_loader #(
    parameter int IMEM_BYTES = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              pc_clear,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;
    localparam logic [2:0] S_RUN     = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    logic [2:0]      state;
    logic [15:0]     count;
    logic [ADDR_W:0] byte_cnt;
    logic [7:0]      csum;

    logic            xfer;
    logic [15:0]     full_count;
    logic [17:0]     full_bytes;
    logic [17:0]     last_idx;
    logic            data_last;

    // Frame arithmetic: the count is evaluated with the low byte still on the bus,
    // and widened so an oversize count can never alias into the legal range.
    assign xfer       = s_valid && s_ready;
    assign full_count = {count[15:8], s_data};
    assign full_bytes = {full_count, 2'b00};
    assign last_idx   = {count, 2'b00} - 18'd1;
    assign data_last  = (18'(byte_cnt) == last_idx);

    // Status outputs depend on state alone, so reset clears them asynchronously.
    always_comb begin
        s_ready    = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CHECK);
        pc_clear   = (state == S_RELEASE);
        cpu_run    = (state == S_RUN);
        load_done  = (state == S_RUN);
        load_error = (state == S_ERROR);
    end

    // Frame sequencer plus the registered IMEM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= 16'd0;
            byte_cnt <= '0;
            csum     <= 8'd0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 8'd0;
        end else begin
            im_we <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start) begin
                        state    <= S_LEN_HI;
                        byte_cnt <= '0;
                        csum     <= 8'd0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        count[15:8] <= s_data;
                        state       <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        count[7:0] <= s_data;
                        if (full_bytes > 18'(IMEM_BYTES)) begin
                            state <= S_ERROR;
                        end else if (full_count == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        im_we    <= 1'b1;
                        im_addr  <= byte_cnt[ADDR_W-1:0];
                        im_wdata <= s_data;
                        csum     <= csum ^ s_data;
                        byte_cnt <= byte_cnt + (ADDR_W+1)'(1);
                        if (data_last) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        state <= (s_data == csum) ? S_RELEASE : S_ERROR;
                    end
                end
                S_RELEASE: begin
                    state <= S_RUN;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       im_we;
    logic [7:0] im_addr;
    logic [7:0] im_wdata;
    logic       pc_clear;
    logic       cpu_run;
    logic       load_done;
    logic       load_error;

    int n_cmp = 0;
    int n_bad = 0;
    int pc_cnt = 0;
    int we_cnt = 0;
    wr_t exp_q[$];
    logic [7:0] exp_mem[256];
    logic [7:0] dut_mem[256];

    imem_boot_loader #(.IMEM_BYTES(256), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .pc_clear(pc_clear), .cpu_run(cpu_run),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every IMEM write pops one expected write from the scoreboard.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst_n) begin
            if (im_we) begin
                we_cnt++;
                dut_mem[im_addr] = im_wdata;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected no write", im_addr, im_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(im_addr), int'(e.addr));
                    check("wr_data", int'(im_wdata), int'(e.data));
                end
            end
            if (pc_clear) pc_cnt++;
            if (pc_clear && cpu_run) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pc_clear_with_run: got both high expected exclusive");
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called just after a negedge; returns just after the negedge following the handshake.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        waited  = 0;
        while (!s_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: got s_ready 0 expected 1 within 20 cycles");
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    function automatic bq_t make_frame(input int n, input logic [7:0] csum_xor);
        bq_t q;
        logic [7:0] cs = 8'd0;
        logic [7:0] b;
        q.push_back(n[15:8]);
        q.push_back(n[7:0]);
        for (int i = 0; i < n * 4; i++) begin
            b = 8'($urandom);
            cs ^= b;
            q.push_back(b);
        end
        q.push_back(cs ^ csum_xor);
        return q;
    endfunction

    // Reference model: frame outcome derived from the framing rules, then driven and checked.
    task automatic run_frame(input bq_t fr, input int gap_mode, input string tag);
        int cnt;
        int used;
        int nwr;
        int bad_idx;
        bit ok;
        logic [7:0] cs;
        wr_t w;
        cnt = int'({fr[0], fr[1]});
        cs  = 8'd0;
        nwr = 0;
        if (cnt * 4 > 256) begin
            used = 2;
            ok   = 1'b0;
        end else begin
            nwr = cnt * 4;
            for (int i = 0; i < nwr; i++) begin
                w.addr = i[7:0];
                w.data = fr[2 + i];
                exp_q.push_back(w);
                exp_mem[i] = fr[2 + i];
                cs ^= fr[2 + i];
            end
            used = 3 + nwr;
            ok   = (fr[2 + nwr] == cs);
        end
        pc_cnt = 0;
        we_cnt = 0;
        pulse_start();
        for (int i = 0; i < used; i++) begin
            int gap;
            if (gap_mode == 0) gap = 0;
            else if (gap_mode == 1) gap = (i > 0) ? 1 : 0;
            else gap = $urandom_range(0, 2);
            send_byte(fr[i], gap);
        end
        repeat (4) @(negedge clk);
        check({tag, "_cpu_run"}, int'(cpu_run), int'(ok));
        check({tag, "_load_done"}, int'(load_done), int'(ok));
        check({tag, "_load_error"}, int'(load_error), int'(!ok));
        check({tag, "_pc_clear_pulses"}, pc_cnt, ok ? 1 : 0);
        check({tag, "_we_pulses"}, we_cnt, nwr);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        check({tag, "_s_ready_idle"}, int'(s_ready), 0);
        bad_idx = -1;
        for (int i = 0; i < 256; i++) begin
            if (dut_mem[i] !== exp_mem[i] && bad_idx < 0) bad_idx = i;
        end
        check({tag, "_imem_first_diff"}, bad_idx, -1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, int'(s_ready), 0);
        check({tag, "_im_we"}, int'(im_we), 0);
        check({tag, "_im_addr"}, int'(im_addr), 0);
        check({tag, "_pc_clear"}, int'(pc_clear), 0);
        check({tag, "_cpu_run"}, int'(cpu_run), 0);
        check({tag, "_load_done"}, int'(load_done), 0);
        check({tag, "_load_error"}, int'(load_error), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bq_t fr;
        logic [31:0] prog [12];
        wr_t w;
        logic [7:0] b;
        prog = '{32'h20080000, 32'h2009000A, 32'h01095020, 32'h21080001,
                 32'h1509FFFD, 32'h00000000, 32'hAC0A0040, 32'h8C0B0040,
                 32'h016B6020, 32'h08000009, 32'h00000000, 32'h00000000};
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = 8'd0;
            dut_mem[i] = 8'd0;
        end
        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        fr = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20};
        run_frame(fr, 0, "single_word");

        fr = '{8'h00, 8'h0C};
        b = 8'd0;
        for (int i = 0; i < 12; i++) begin
            for (int k = 3; k >= 0; k--) begin
                fr.push_back(prog[i][8*k +: 8]);
                b ^= prog[i][8*k +: 8];
            end
        end
        fr.push_back(b);
        run_frame(fr, 1, "loop12_toggle");

        fr = '{8'h00, 8'h01, 8'hAC, 8'h03, 8'h00, 8'h0B, 8'hFF};
        run_frame(fr, 0, "bad_csum");
        run_frame(make_frame(3, 8'h00), 2, "recover");

        fr = '{8'h00, 8'h41};
        run_frame(fr, 0, "oversize");

        fr = '{8'h00, 8'h00, 8'h00};
        run_frame(fr, 0, "zero_ok");
        fr = '{8'h00, 8'h00, 8'h01};
        run_frame(fr, 0, "zero_bad");

        run_frame(make_frame(64, 8'h00), 0, "full_imem");

        // Reset partway through the data phase of a two-word frame.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            w.addr = i[7:0];
            w.data = b;
            exp_q.push_back(w);
            exp_mem[i] = b;
            send_byte(b, 0);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("start_in_reset_ignored", int'(s_ready), 0);
        check("reset_cpu_run", int'(cpu_run), 0);
        check("reset_pending_writes", exp_q.size(), 0);
        run_frame(make_frame(2, 8'h00), 0, "after_reset");

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(0, 64);
            if ($urandom_range(0, 5) == 0) begin
                n = $urandom_range(65, 4000);
                fr = '{};
                fr.push_back(n[15:8]);
                fr.push_back(n[7:0]);
                run_frame(fr, 2, "rand_oversize");
            end else begin
                run_frame(make_frame(n, ($urandom_range(0, 3) == 0) ? 8'h5A : 8'h00), 2, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Upstream feeder for the MIPS single-cycle processor: receives a program as a byte stream over a valid/ready handshake and writes it big-endian into the byte-addressed instruction memory. It holds the processor stalled while loading, then pulses a PC clear and releases the processor. Framing is a 16-bit word count, then the payload, then an XOR checksum. Bad frames are rejected and latched as an error.

## Interface
- IMEM_BYTES, 256: instruction memory size in bytes; must be a power of two and a multiple of 4.
- ADDR_W, 8: byte address width, equal to log2(IMEM_BYTES).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, RUN or ERROR.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_ready  out  1  loader accepts a byte; a transfer occurs when s_valid and s_ready are both high.
- im_we  out  1  IMEM byte write strobe.
- im_addr  out  ADDR_W  IMEM byte address.
- im_wdata  out  8  IMEM byte data.
- pc_clear  out  1  one-cycle pulse that forces the processor PC to 0.
- cpu_run  out  1  processor clock-enable; high only after a successful load.
- load_done  out  1  high while in RUN.
- load_error  out  1  high while in ERROR.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, RELEASE, RUN, ERROR.
- Reset state is IDLE. All outputs reset to 0, including im_addr. Internal word count, byte counter and checksum also reset to 0.
- IDLE, RUN or ERROR with start=1:
  - Go to LEN_HI.
  - Clear the byte counter and checksum.
  - Drop cpu_run, load_done and load_error in the same edge.
- start in any other state is ignored.
- LEN_HI: accept one byte as count[15:8].
- LEN_LO: accept one byte as count[7:0]. Then evaluate the full count:
  - count*4 > IMEM_BYTES goes to ERROR.
  - count == 0 goes to CHECK.
  - Otherwise go to DATA.
- Length bytes are not included in the checksum.
- DATA: each accepted byte
  - writes IMEM at the byte counter, so byte k of word w lands at address 4w+k (MSB first, big-endian);
  - is XORed into the checksum;
  - increments the byte counter.
- After byte count*4-1 is accepted, go to CHECK.
- CHECK: accept one byte.
  - Equal to the running checksum: go to RELEASE.
  - Otherwise: go to ERROR.
- RELEASE: a single cycle that asserts pc_clear, then go to RUN.
- RUN: cpu_run=1 and load_done=1.
- ERROR: load_error=1 and cpu_run=0. IMEM contents already written are left as-is.
- s_ready:
  - high exactly in LEN_HI, LEN_LO, DATA and CHECK;
  - combinational from state only, never from s_valid.
- Address arithmetic:
  - the byte counter is ADDR_W+1 bits wide, so a full IMEM (IMEM_BYTES bytes) is legal;
  - im_addr is the counter's low ADDR_W bits;
  - the counter never wraps within a frame, because the overflow check precedes DATA.

## Timing
- Write latency is 1 cycle: a byte accepted at edge n drives im_we=1, im_addr and im_wdata during cycle n+1 (registered).
- im_we is high for exactly one cycle per accepted DATA byte.
- With s_valid held high, DATA accepts one byte per cycle. Stalls (s_valid=0) add no extra writes.
- After the last data byte, the checksum byte is accepted at the next handshake, so the minimum is 1 cycle after the last data byte.
- Timeline for a successful load, counting from checksum acceptance at edge c:
  - RELEASE is active in cycle c+1, with pc_clear=1;
  - cpu_run=1 from edge c+2 onward;
  - pc_clear and cpu_run are never high in the same cycle.
- Minimum total load, from start to cpu_run, is 2 + 4N + 1 + 2 cycles for N words.
- Reset mid-load:
  - the state returns to IDLE immediately (asynchronously);
  - im_we drops immediately, so a partially written word may remain in IMEM;
  - cpu_run stays 0 until a new successful load.
- start asserted in the same cycle as a handshake in a loading state: the handshake proceeds and start is ignored.

## Test plan
- Single word: start, then bytes 00 01 00 00 00 20 20 → IM[0..3]=00,00,00,20; pc_clear one cycle; cpu_run=1; load_done=1.
- Twelve-word loop program with s_valid toggling 1/0 each cycle → IM[0..47] match the words byte-exact; im_we pulses exactly 48 times; checksum accepted.
- Checksum wrong (00 01 AC 03 00 0B then FF) → load_error=1; cpu_run=0; IM[0..3]=AC,03,00,0B; a following start plus a valid frame recovers to RUN.
- Oversize count 00 41 (65 words > 256 B) → ERROR immediately after LEN_LO; no im_we pulses.
- Zero count 00 00 00 → RUN with no writes. Zero count 00 00 01 → ERROR.
- rst_n low after 6 data bytes → all outputs 0 asynchronously; start ignored while rst_n=0; after release and a full valid frame → correct RUN.
